cla_adder_pipe: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor. Generalises the team's registered 4-bit CLA adder to any width that is a multiple of the lookahead group size. Adds a subtract mode, a signed-overflow flag, valid tagging and a global stall. Used wherever the datapath needs one add/sub per clock at widths too large for a single-cycle ripple or flat CLA.

---
 rtl/cla_adder_pipe.sv | 150 +++++++++++++++
 tb/tb_cla_adder_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: three-stage carry-lookahead adder/subtractor.
// S0 conditions operands, S1 forms g/p and group G/P, S2 resolves carries.
module cla_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             Cout,
    output logic             ovf
);
    localparam int NG = WIDTH / GROUP;

    logic [WIDTH-1:0] a_s0;
    logic [WIDTH-1:0] b_s0;
    logic             c_s0;
    logic             v_s0;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_s0 <= '0;
            b_s0 <= '0;
            c_s0 <= 1'b0;
            v_s0 <= 1'b0;
        end else if (en) begin
            a_s0 <= d1;
            b_s0 <= d2 ^ {WIDTH{sub}};
            c_s0 <= Cin ^ sub;
            v_s0 <= in_valid;
        end
    end

    logic [WIDTH-1:0] g_c;
    logic [WIDTH-1:0] p_c;
    logic [NG-1:0]    gg_c;
    logic [NG-1:0]    pg_c;

    always_comb begin
        logic t;
        t    = 1'b0;
        g_c  = a_s0 & b_s0;
        p_c  = a_s0 ^ b_s0;
        gg_c = '0;
        pg_c = '1;
        for (int j = 0; j < NG; j++) begin
            for (int i = 0; i < GROUP; i++) begin
                pg_c[j] = pg_c[j] & p_c[j*GROUP+i];
                t = g_c[j*GROUP+i];
                for (int k = i + 1; k < GROUP; k++)
                    t = t & p_c[j*GROUP+k];
                gg_c[j] = gg_c[j] | t;
            end
        end
    end

    logic [WIDTH-1:0] p_s1;
    logic [WIDTH-1:0] g_s1;
    logic [NG-1:0]    gg_s1;
    logic [NG-1:0]    pg_s1;
    logic             c_s1;
    logic             v_s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            p_s1  <= '0;
            g_s1  <= '0;
            gg_s1 <= '0;
            pg_s1 <= '0;
            c_s1  <= 1'b0;
            v_s1  <= 1'b0;
        end else if (en) begin
            p_s1  <= p_c;
            g_s1  <= g_c;
            gg_s1 <= gg_c;
            pg_s1 <= pg_c;
            c_s1  <= c_s0;
            v_s1  <= v_s0;
        end
    end

    logic [NG:0]      cg_c;
    logic [WIDTH-1:0] cb_c;
    logic [WIDTH-1:0] sum_c;
    logic             unused_gtop;

    // Every carry is a flat sum of products; nothing ripples.
    always_comb begin
        logic t;
        logic acc;
        t           = 1'b0;
        acc         = 1'b0;
        cg_c        = '0;
        cb_c        = '0;
        unused_gtop = 1'b0;
        cg_c[0]     = c_s1;
        for (int j = 0; j < NG; j++) begin
            acc = c_s1;
            for (int k = 0; k <= j; k++)
                acc = acc & pg_s1[k];
            for (int i = 0; i <= j; i++) begin
                t = gg_s1[i];
                for (int k = i + 1; k <= j; k++)
                    t = t & pg_s1[k];
                acc = acc | t;
            end
            cg_c[j+1] = acc;
        end
        for (int j = 0; j < NG; j++) begin
            for (int b = 0; b < GROUP; b++) begin
                acc = cg_c[j];
                for (int k = 0; k < b; k++)
                    acc = acc & p_s1[j*GROUP+k];
                for (int i = 0; i < b; i++) begin
                    t = g_s1[j*GROUP+i];
                    for (int k = i + 1; k < b; k++)
                        t = t & p_s1[j*GROUP+k];
                    acc = acc | t;
                end
                cb_c[j*GROUP+b] = acc;
            end
            unused_gtop = unused_gtop ^ g_s1[j*GROUP+GROUP-1];
        end
        sum_c = p_s1 ^ cb_c;
    end

    // Results only load for valid tokens so bubbles leave them held.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            sum       <= '0;
            Cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (en) begin
            out_valid <= v_s1;
            if (v_s1) begin
                sum  <= sum_c;
                Cout <= cg_c[NG];
                ovf  <= cb_c[WIDTH-1] ^ cg_c[NG];
            end
        end
    end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: directed checks of the 16-bit pipe plus a
// width/group sweep against an arithmetic reference model.
module tb_cla_adder_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, en, in_valid, cin, sub;
    logic [15:0] d1, d2;
    logic        out_valid, cout, ovf;
    logic [15:0] sum;

    logic        s_iv, s_cin, s_sub;
    logic [31:0] s_d1, s_d2;
    logic        v4, co4, of4;
    logic [3:0]  sum4;
    logic        v8, co8, of8;
    logic [7:0]  sum8;
    logic        v32, co32, of32;
    logic [31:0] sum32;
    logic        v12, co12, of12;
    logic [11:0] sum12;

    int nvec = 0;
    int nerr = 0;

    cla_adder_pipe #(.WIDTH(16), .GROUP(4)) dut (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid),
        .d1(d1), .d2(d2), .Cin(cin), .sub(sub),
        .out_valid(out_valid), .sum(sum), .Cout(cout), .ovf(ovf));

    cla_adder_pipe #(.WIDTH(4), .GROUP(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .in_valid(s_iv),
        .d1(s_d1[3:0]), .d2(s_d2[3:0]), .Cin(s_cin), .sub(s_sub),
        .out_valid(v4), .sum(sum4), .Cout(co4), .ovf(of4));

    cla_adder_pipe #(.WIDTH(8), .GROUP(2)) dut8 (
        .clk(clk), .reset(reset), .en(en), .in_valid(s_iv),
        .d1(s_d1[7:0]), .d2(s_d2[7:0]), .Cin(s_cin), .sub(s_sub),
        .out_valid(v8), .sum(sum8), .Cout(co8), .ovf(of8));

    cla_adder_pipe #(.WIDTH(32), .GROUP(8)) dut32 (
        .clk(clk), .reset(reset), .en(en), .in_valid(s_iv),
        .d1(s_d1), .d2(s_d2), .Cin(s_cin), .sub(s_sub),
        .out_valid(v32), .sum(sum32), .Cout(co32), .ovf(of32));

    cla_adder_pipe #(.WIDTH(12), .GROUP(1)) dut12 (
        .clk(clk), .reset(reset), .en(en), .in_valid(s_iv),
        .d1(s_d1[11:0]), .d2(s_d2[11:0]), .Cin(s_cin), .sub(s_sub),
        .out_valid(v12), .sum(sum12), .Cout(co12), .ovf(of12));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Result packed as {ovf, Cout, sum} from plain integer arithmetic.
    function automatic logic [33:0] model(input int w,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic c,
                                          input logic s);
        logic [63:0] m, aa, bb, full;
        logic [31:0] sm;
        logic co, of;
        m    = (64'd1 << w) - 64'd1;
        aa   = {32'd0, a} & m;
        bb   = {32'd0, (s ? ~b : b)} & m;
        full = aa + bb + {63'd0, c ^ s};
        sm   = full[31:0] & m[31:0];
        co   = full[w];
        of   = (aa[w-1] == bb[w-1]) && (sm[w-1] != aa[w-1]);
        return {of, co, sm};
    endfunction

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            tick;
            nvec++;
            if ({out_valid, cout, ovf, sum} !== 19'h0) begin
                nerr++;
                $display("FAIL reset[%0d]: got %h, want 0",
                         i, {out_valid, cout, ovf, sum});
            end
        end
    endtask

    task automatic test_latency;
        logic [18:0] exp [4];
        exp = '{19'h0, 19'h0, {3'b100, 16'h2233}, {3'b000, 16'h2233}};
        d1 = 16'h1234; d2 = 16'h0FFF; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick;
            nvec++;
            if ({out_valid, cout, ovf, sum} !== exp[i]) begin
                nerr++;
                $display("FAIL latency[%0d]: got %h, want %h",
                         i, {out_valid, cout, ovf, sum}, exp[i]);
            end
        end
    endtask

    task automatic test_corners;
        logic [15:0] a [3];
        logic [15:0] b [3];
        logic        c [3];
        logic [18:0] exp [4];
        a = '{16'hFFFF, 16'h7FFF, 16'hFFFF};
        b = '{16'h0001, 16'h0001, 16'hFFFF};
        c = '{1'b0, 1'b0, 1'b1};
        exp = '{{3'b110, 16'h0000}, {3'b101, 16'h8000},
                {3'b110, 16'hFFFF}, {3'b010, 16'hFFFF}};
        for (int i = 0; i < 6; i++) begin
            if (i < 3) begin
                d1 = a[i]; d2 = b[i]; cin = c[i]; sub = 1'b0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick;
            if (i >= 2) begin
                nvec++;
                if ({out_valid, cout, ovf, sum} !== exp[i-2]) begin
                    nerr++;
                    $display("FAIL corners[%0d]: got %h, want %h",
                             i - 2, {out_valid, cout, ovf, sum}, exp[i-2]);
                end
            end
        end
    endtask

    task automatic test_subtract;
        logic [15:0] a [4];
        logic [15:0] b [4];
        logic        c [4];
        logic [18:0] exp [5];
        a = '{16'h0005, 16'h0003, 16'h8000, 16'h0005};
        b = '{16'h0003, 16'h0005, 16'h0001, 16'h0003};
        c = '{1'b0, 1'b0, 1'b0, 1'b1};
        exp = '{{3'b110, 16'h0002}, {3'b100, 16'hFFFE},
                {3'b111, 16'h7FFF}, {3'b110, 16'h0001},
                {3'b010, 16'h0001}};
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                d1 = a[i]; d2 = b[i]; cin = c[i]; sub = 1'b1;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick;
            if (i >= 2) begin
                nvec++;
                if ({out_valid, cout, ovf, sum} !== exp[i-2]) begin
                    nerr++;
                    $display("FAIL subtract[%0d]: got %h, want %h",
                             i - 2, {out_valid, cout, ovf, sum}, exp[i-2]);
                end
            end
        end
        sub = 1'b0;
    endtask

    task automatic test_bubble;
        logic [15:0] a [3];
        logic [15:0] b [3];
        logic        v [3];
        logic [18:0] exp [4];
        a = '{16'h1111, 16'hDEAD, 16'h4000};
        b = '{16'h2222, 16'hBEEF, 16'h4000};
        v = '{1'b1, 1'b0, 1'b1};
        exp = '{{3'b100, 16'h3333}, {3'b000, 16'h3333},
                {3'b101, 16'h8000}, {3'b001, 16'h8000}};
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                d1 = a[i]; d2 = b[i]; cin = 1'b0; sub = 1'b0;
                in_valid = v[i];
            end else begin
                in_valid = 1'b0;
            end
            tick;
            if (i >= 2) begin
                nvec++;
                if ({out_valid, cout, ovf, sum} !== exp[i-2]) begin
                    nerr++;
                    $display("FAIL bubble[%0d]: got %h, want %h",
                             i - 2, {out_valid, cout, ovf, sum}, exp[i-2]);
                end
            end
        end
    endtask

    task automatic test_stall;
        logic [15:0] a [3];
        logic [15:0] b [3];
        logic [18:0] exp [4];
        a = '{16'h0001, 16'h0010, 16'h0100};
        b = '{16'h0001, 16'h0020, 16'h0200};
        exp = '{{3'b100, 16'h0030}, {3'b100, 16'h0300},
                {3'b000, 16'h0300}, {3'b000, 16'h0300}};
        for (int i = 0; i < 3; i++) begin
            d1 = a[i]; d2 = b[i]; cin = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        nvec++;
        if ({out_valid, cout, ovf, sum} !== {3'b100, 16'h0002}) begin
            nerr++;
            $display("FAIL stall_pre: got %h, want %h",
                     {out_valid, cout, ovf, sum}, {3'b100, 16'h0002});
        end
        en = 1'b0;
        d1 = 16'hFFFF; d2 = 16'h0001; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            nvec++;
            if ({out_valid, cout, ovf, sum} !== {3'b100, 16'h0002}) begin
                nerr++;
                $display("FAIL stall_hold[%0d]: got %h, want %h",
                         i, {out_valid, cout, ovf, sum}, {3'b100, 16'h0002});
            end
        end
        en = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            nvec++;
            if ({out_valid, cout, ovf, sum} !== exp[i]) begin
                nerr++;
                $display("FAIL stall_post[%0d]: got %h, want %h",
                         i, {out_valid, cout, ovf, sum}, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [18:0] exp [4];
        exp = '{19'h0, 19'h0, 19'h0, {3'b100, 16'h0005}};
        d1 = 16'h0AAA; d2 = 16'h0555; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        tick;
        d1 = 16'h1000; d2 = 16'h0001;
        tick;
        in_valid = 1'b0;
        reset = 1'b1;
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                reset = 1'b0; en = 1'b1;
                d1 = 16'h0002; d2 = 16'h0003; in_valid = 1'b1;
            end
            tick;
            in_valid = 1'b0;
            nvec++;
            if ({out_valid, cout, ovf, sum} !== exp[i]) begin
                nerr++;
                $display("FAIL reset_mid[%0d]: got %h, want %h",
                         i, {out_valid, cout, ovf, sum}, exp[i]);
            end
        end
    endtask

    task automatic test_sweep;
        logic [33:0] r;
        for (int n = 0; n < 16; n++) begin
            if (n == 0) begin
                s_d1 = 32'hF; s_d2 = 32'hF; s_cin = 1'b0; s_sub = 1'b0;
            end else begin
                s_d1 = $urandom(); s_d2 = $urandom();
                s_cin = 1'($urandom_range(1)); s_sub = 1'($urandom_range(1));
            end
            s_iv = 1'b1;
            tick;
            s_iv = 1'b0;
            tick;
            tick;
            if (n == 0) begin
                nvec++;
                if ({v4, co4, of4, sum4} !== {3'b110, 4'b1110}) begin
                    nerr++;
                    $display("FAIL w4_allones: got %b, want %b",
                             {v4, co4, of4, sum4}, {3'b110, 4'b1110});
                end
            end
            r = model(4, s_d1, s_d2, s_cin, s_sub);
            nvec++;
            if ({v4, co4, of4, sum4} !== {1'b1, r[32], r[33], r[3:0]}) begin
                nerr++;
                $display("FAIL w4g4[%0d]: got %h, want %h", n,
                         {v4, co4, of4, sum4}, {1'b1, r[32], r[33], r[3:0]});
            end
            r = model(8, s_d1, s_d2, s_cin, s_sub);
            nvec++;
            if ({v8, co8, of8, sum8} !== {1'b1, r[32], r[33], r[7:0]}) begin
                nerr++;
                $display("FAIL w8g2[%0d]: got %h, want %h", n,
                         {v8, co8, of8, sum8}, {1'b1, r[32], r[33], r[7:0]});
            end
            r = model(32, s_d1, s_d2, s_cin, s_sub);
            nvec++;
            if ({v32, co32, of32, sum32} !== {1'b1, r[32], r[33], r[31:0]}) begin
                nerr++;
                $display("FAIL w32g8[%0d]: got %h, want %h", n,
                         {v32, co32, of32, sum32}, {1'b1, r[32], r[33], r[31:0]});
            end
            r = model(12, s_d1, s_d2, s_cin, s_sub);
            nvec++;
            if ({v12, co12, of12, sum12} !== {1'b1, r[32], r[33], r[11:0]}) begin
                nerr++;
                $display("FAIL w12g1[%0d]: got %h, want %h", n,
                         {v12, co12, of12, sum12}, {1'b1, r[32], r[33], r[11:0]});
            end
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; in_valid = 1'b0;
        d1 = '0; d2 = '0; cin = 1'b0; sub = 1'b0;
        s_iv = 1'b0; s_d1 = '0; s_d2 = '0; s_cin = 1'b0; s_sub = 1'b0;
        test_reset;
        reset = 1'b0;
        test_latency;
        test_corners;
        test_subtract;
        test_bubble;
        test_stall;
        test_reset_mid;
        test_sweep;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
